// File: rtl/agu_multi.sv
//------------------------------------------------------------------------------
// agu_multi : N-lane RV32 load/store address generation with in-order queue
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 11
`endif
`ifndef DECINFO_GRP_BUS
`define DECINFO_GRP_BUS 2:0
`endif
`ifndef DECINFO_GRP_MEM
`define DECINFO_GRP_MEM 3'd3
`endif
`ifndef DECINFO_MEM_OP_BUS
`define DECINFO_MEM_OP_BUS 10:3
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module agu_multi #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int BUS_W = 64
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush_i,
  input  logic [LANES-1:0]                             inst_valid_i,
  input  logic [LANES-1:0][31:0]                       rs1_i,
  input  logic [LANES-1:0][31:0]                       rs2_i,
  input  logic [LANES-1:0][31:0]                       imm_i,
  input  logic [LANES-1:0][`DECINFO_WIDTH-1:0]         dec_i,
  input  logic [LANES-1:0][`COMMIT_ID_WIDTH-1:0]       commit_id_i,
  input  logic [LANES-1:0][`REG_ADDR_WIDTH-1:0]        mem_reg_waddr_i,
  output logic                                         issue_ready_o,
  output logic                                         agu_stall_req,
  input  logic                                         lsu_ready_i,
  output logic                                         mem_req_o,
  output logic [31:0]                                  addr_o,
  output logic [BUS_W/8-1:0]                           wmask_o,
  output logic [BUS_W-1:0]                             wdata_o,
  output logic [`COMMIT_ID_WIDTH-1:0]                  commit_id_o,
  output logic [`REG_ADDR_WIDTH-1:0]                   mem_reg_waddr_o,
  output logic                                         mem_op_lb_o,
  output logic                                         mem_op_lh_o,
  output logic                                         mem_op_lw_o,
  output logic                                         mem_op_lbu_o,
  output logic                                         mem_op_lhu_o,
  output logic                                         mem_op_load_o,
  output logic                                         mem_op_store_o,
  output logic                                         misaligned_load_o,
  output logic                                         misaligned_store_o,
  output logic [$clog2(DEPTH):0]                       occupancy_o,
  output logic                                         agu_atom_lock
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NB   = BUS_W / 8;
  localparam int OFFW = $clog2(NB);

  // op bit order: lb, lh, lw, lbu, lhu, sb, sh, sw
  typedef struct packed {
    logic [31:0]                  addr;
    logic [31:0]                  data;
    logic [7:0]                   op;
    logic [`COMMIT_ID_WIDTH-1:0]  cid;
    logic [`REG_ADDR_WIDTH-1:0]   rd;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      occ_q, occ_d;

  entry_t [LANES-1:0] lane_ent;
  logic [LANES-1:0]   lane_mem, acc_mem, byp_oh, push_lane;
  entry_t             byp_ent, cur;
  logic               issue_ready, head_sel, byp_found, byp_consume, pop, req;
  logic [CW-1:0]      push_cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_mem[k]      = inst_valid_i[k] && (dec_i[k][`DECINFO_GRP_BUS] == `DECINFO_GRP_MEM);
    assign lane_ent[k].addr = rs1_i[k] + imm_i[k];
    assign lane_ent[k].data = rs2_i[k];
    assign lane_ent[k].op   = dec_i[k][`DECINFO_MEM_OP_BUS];
    assign lane_ent[k].cid  = commit_id_i[k];
    assign lane_ent[k].rd   = mem_reg_waddr_i[k];
  end

  assign issue_ready = (occ_q <= CW'(DEPTH - LANES)) && !flush_i;
  assign acc_mem     = lane_mem & {LANES{issue_ready}};
  assign byp_oh      = acc_mem & (~acc_mem + LANES'(1));
  assign byp_found   = |acc_mem;
  assign head_sel    = (occ_q != '0);
  // The bypassed op is only kept when the LSU does not take it this cycle.
  assign byp_consume = !head_sel && byp_found && lsu_ready_i;
  assign push_lane   = acc_mem & ~(byp_consume ? byp_oh : '0);
  assign pop         = head_sel && lsu_ready_i && !flush_i;

  always_comb begin
    byp_ent  = '0;
    mem_d    = mem_q;
    push_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      if (byp_oh[k]) byp_ent = lane_ent[k];
      if (push_lane[k]) begin
        mem_d[tail_q + push_cnt[AW-1:0]] = lane_ent[k];
        push_cnt = push_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    head_d = head_q + AW'(pop);
    tail_d = tail_q + push_cnt[AW-1:0];
    occ_d  = occ_q + push_cnt - CW'(pop);
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign cur = head_sel ? mem_q[head_q] : byp_ent;
  assign req = !flush_i && (head_sel || byp_found);

  logic [OFFW-1:0] off, off_h, off_w;
  logic            is_load, is_store, is_half, is_word, mis;
  logic [NB-1:0]   mask;
  logic [BUS_W-1:0] data;

  always_comb begin
    off      = cur.addr[OFFW-1:0];
    off_h    = off & ~OFFW'(1);
    off_w    = off & ~OFFW'(3);
    is_load  = |cur.op[4:0];
    is_store = |cur.op[7:5];
    is_half  = cur.op[1] | cur.op[4] | cur.op[6];
    is_word  = cur.op[2] | cur.op[7];
    mis      = (is_half && cur.addr[0]) || (is_word && (cur.addr[1:0] != 2'b00));
    if (is_word) begin
      mask = NB'(4'hF) << off_w;
      data = BUS_W'(cur.data) << {off_w, 3'b000};
    end else if (is_half) begin
      mask = NB'(2'h3) << off_h;
      data = BUS_W'(cur.data[15:0]) << {off_h, 3'b000};
    end else begin
      mask = NB'(1'b1) << off;
      data = BUS_W'(cur.data[7:0]) << {off, 3'b000};
    end

    mem_req_o          = req;
    addr_o             = '0;
    wmask_o            = '0;
    wdata_o            = '0;
    commit_id_o        = '0;
    mem_reg_waddr_o    = '0;
    mem_op_lb_o        = 1'b0;
    mem_op_lh_o        = 1'b0;
    mem_op_lw_o        = 1'b0;
    mem_op_lbu_o       = 1'b0;
    mem_op_lhu_o       = 1'b0;
    mem_op_load_o      = 1'b0;
    mem_op_store_o     = 1'b0;
    misaligned_load_o  = 1'b0;
    misaligned_store_o = 1'b0;
    if (req) begin
      addr_o             = cur.addr;
      // Misaligned stores never write; the LSU turns the flag into a trap.
      wmask_o            = (is_store && !mis) ? mask : '0;
      wdata_o            = is_store ? data : '0;
      commit_id_o        = cur.cid;
      mem_reg_waddr_o    = cur.rd;
      mem_op_lb_o        = cur.op[0];
      mem_op_lh_o        = cur.op[1];
      mem_op_lw_o        = cur.op[2];
      mem_op_lbu_o       = cur.op[3];
      mem_op_lhu_o       = cur.op[4];
      mem_op_load_o      = is_load;
      mem_op_store_o     = is_store;
      misaligned_load_o  = is_load && mis;
      misaligned_store_o = is_store && mis;
    end
  end

  assign issue_ready_o = issue_ready;
  assign agu_stall_req = !issue_ready && (|lane_mem);
  assign occupancy_o   = occ_q;
  assign agu_atom_lock = head_sel;

endmodule

`default_nettype wire
